// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, address alignment and the completer FSM state type.
package apb_pkg;
  localparam int APB_DW    = 32;
  localparam int APB_SW    = 4;
  localparam int APB_ALIGN = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_t;
endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between master and completer. PSTRB exists only with APB_SLAVE_PSTRB_EN.
// Handshake: a transfer is a setup cycle (PSELx=1, PENABLE=0) followed by access cycles
// (PSELx=1, PENABLE=1) that complete on the cycle where PREADY=1; PSLVERR/PRDATA are valid only then.
interface apb_slave_regfile_if;
  import apb_pkg::*;

  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_DW-1:0] PADDR;
  logic [APB_DW-1:0] PWDATA;
`ifdef APB_SLAVE_PSTRB_EN
  logic [APB_SW-1:0] PSTRB;
`endif
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
    output PSTRB,
`endif
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
    input  PSTRB,
`endif
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_regfile_decode.sv
// Combinational address decode for the register file: word index plus error qualifiers.
module apb_slave_decode
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int RO_INDEX = NUM_REGS - 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic [APB_DW-1:0] i_paddr,
  output logic [AW-1:0]     o_index,
  output logic              o_out_of_range,
  output logic              o_misaligned,
  output logic              o_ro_hit
);
  assign o_index        = i_paddr[APB_ALIGN +: AW];
  assign o_out_of_range = |i_paddr[APB_DW-1:APB_ALIGN+AW];
  assign o_misaligned   = |i_paddr[APB_ALIGN-1:0];
  assign o_ro_hit       = (o_index == AW'(RO_INDEX)) && !o_out_of_range;
endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with NUM_REGS 32-bit registers, WAIT_STATES access wait cycles and a read-only
// status slot. Byte-lane writes are enabled by defining APB_SLAVE_PSTRB_EN.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0,
  parameter int RO_INDEX    = NUM_REGS - 1
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  apb_slave_regfile_if.slave       apb,
  input  logic [APB_DW-1:0]        STATUS_IN,
  output logic [32*NUM_REGS-1:0]   REGS_OUT,
  output apb_state_t               o_dbg_state
);
  localparam int AW = $clog2(NUM_REGS);

  logic [APB_DW-1:0] r_regs [NUM_REGS];
  apb_state_t        r_state;
  logic [3:0]        r_cnt;
  logic [AW-1:0]     r_idx;
  logic              r_err;
  logic              r_write;
  logic              r_pready;
  logic              r_pslverr;
  logic [APB_DW-1:0] r_prdata;

  logic [AW-1:0]     w_idx;
  logic              w_oor;
  logic              w_mis;
  logic              w_ro;
  logic              w_err;
  logic              w_setup;
  logic              w_commit;
  logic [APB_DW-1:0] w_live_rd;
  logic [APB_DW-1:0] w_lat_rd;
  logic [APB_DW-1:0] w_wmask;

  apb_slave_decode #(
    .NUM_REGS (NUM_REGS),
    .RO_INDEX (RO_INDEX),
    .AW       (AW)
  ) u_decode (
    .i_paddr        (apb.PADDR),
    .o_index        (w_idx),
    .o_out_of_range (w_oor),
    .o_misaligned   (w_mis),
    .o_ro_hit       (w_ro)
  );

  assign w_err     = w_mis | w_oor | (apb.PWRITE & w_ro);
  assign w_setup   = apb.PSELx & !apb.PENABLE;
  assign w_live_rd = (w_idx == AW'(RO_INDEX)) ? STATUS_IN : r_regs[w_idx];
  assign w_lat_rd  = (r_idx == AW'(RO_INDEX)) ? STATUS_IN : r_regs[r_idx];
  // Registered PREADY/PSLVERR qualify the commit, so a write lands only on the completing edge.
  assign w_commit  = apb.PSELx & apb.PENABLE & apb.PWRITE & r_pready & !r_pslverr;

  always_comb begin
    w_wmask = '1;
`ifdef APB_SLAVE_PSTRB_EN
    for (int b = 0; b < APB_SW; b++) begin
      w_wmask[8*b +: 8] = {8{apb.PSTRB[b]}};
    end
`endif
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_write   <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
          if (w_setup) begin
            r_idx   <= w_idx;
            r_err   <= w_err;
            r_write <= apb.PWRITE;
            if (WAIT_STATES == 0) begin
              r_state   <= DONE;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= (!apb.PWRITE && !w_err) ? w_live_rd : '0;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (!apb.PSELx) begin
            r_state <= IDLE;
          end else if (r_cnt == 4'd1) begin
            r_state   <= DONE;
            r_pready  <= 1'b1;
            r_pslverr <= r_err;
            r_prdata  <= (!r_write && !r_err) ? w_lat_rd : '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[r_idx] <= (r_regs[r_idx] & ~w_wmask) | (apb.PWDATA & w_wmask);
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign REGS_OUT[32*g +: 32] = r_regs[g];
  end

  assign apb.PREADY  = r_pready;
  assign apb.PSLVERR = r_pslverr;
  assign apb.PRDATA  = r_prdata;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed + random bench for apb_slave_regfile: one instance with 0 and one with 3 wait states.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  localparam int NR = 16;

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  logic        m_psel, m_pen, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_strb;
  int          m_dut;
  logic [31:0] status_in;

  apb_slave_regfile_if bus0();
  apb_slave_regfile_if bus3();

  assign bus0.PSELx   = m_psel && (m_dut == 0);
  assign bus0.PENABLE = m_pen;
  assign bus0.PWRITE  = m_wr;
  assign bus0.PADDR   = m_addr;
  assign bus0.PWDATA  = m_wdata;
  assign bus3.PSELx   = m_psel && (m_dut == 1);
  assign bus3.PENABLE = m_pen;
  assign bus3.PWRITE  = m_wr;
  assign bus3.PADDR   = m_addr;
  assign bus3.PWDATA  = m_wdata;
`ifdef APB_SLAVE_PSTRB_EN
  assign bus0.PSTRB   = m_strb;
  assign bus3.PSTRB   = m_strb;
`endif

  logic [32*NR-1:0] regs0, regs3;
  apb_state_t       st0, st3;

  apb_slave_regfile #(.NUM_REGS(NR), .WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus0.slave), .STATUS_IN(status_in),
    .REGS_OUT(regs0), .o_dbg_state(st0)
  );
  apb_slave_regfile #(.NUM_REGS(NR), .WAIT_STATES(3)) dut3 (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus3.slave), .STATUS_IN(status_in),
    .REGS_OUT(regs3), .o_dbg_state(st3)
  );

  int          vectors = 0;
  int          fails   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model [2][NR];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return d != 0 ? bus3.PREADY : bus0.PREADY;
  endfunction

  function automatic logic [31:0] regword(input int d, input int idx);
    return d != 0 ? regs3[32*idx +: 32] : regs0[32*idx +: 32];
  endfunction

  function automatic logic [3:0] eff_strb(input logic [3:0] s);
`ifdef APB_SLAVE_PSTRB_EN
    return s;
`else
    return 4'hF;
`endif
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) model[d][i] = '0;
  endtask

  // Reference behaviour: push the expected {err, rdata} and update the model for legal writes.
  task automatic expect_xfer(input int d, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb);
    int   idx;
    logic err;
    logic [3:0] s;
    idx = int'(addr[5:2]);
    err = (addr[1:0] != 2'b00) || (addr >= 32'(4*NR)) || (wr && idx == NR-1);
    if (wr) begin
      if (!err) begin
        s = eff_strb(strb);
        for (int b = 0; b < 4; b++)
          if (s[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
      end
      exp_q.push_back({err, 32'h0});
    end else begin
      exp_q.push_back({err, err ? 32'h0 : (idx == NR-1 ? status_in : model[d][idx])});
    end
  endtask

  // Drives setup then access until PREADY (bounded); leaves the bus ready for a back-to-back setup.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err, output int acc,
                      output logic [31:0] pre, output logic [31:0] post);
    int idx;
    idx = int'(addr[5:2]);
    m_dut = d; m_psel = 1'b1; m_pen = 1'b0; m_wr = wr;
    m_addr = addr; m_wdata = wdata; m_strb = strb;
    @(posedge PCLK); #1;
    m_pen = 1'b1;
    acc = 1;
    while (!rdy(d) && acc < 40) begin
      @(posedge PCLK); #1;
      acc++;
    end
    rd   = d != 0 ? bus3.PRDATA : bus0.PRDATA;
    err  = d != 0 ? bus3.PSLVERR : bus0.PSLVERR;
    pre  = regword(d, idx);
    @(posedge PCLK); #1;
    post = regword(d, idx);
    m_psel = 1'b0; m_pen = 1'b0;
  endtask

  task automatic run(input int d, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb, input string tag);
    logic [31:0] rd, pre, post;
    logic        err;
    int          acc;
    logic [32:0] e;
    expect_xfer(d, wr, addr, wdata, strb);
    xfer(d, wr, addr, wdata, strb, rd, err, acc, pre, post);
    e = exp_q.pop_front();
    check({tag, "_acc"}, 64'(acc), 64'(d != 0 ? 4 : 1));
    check({tag, "_err"}, 64'(err), 64'(e[32]));
    if (!wr) check({tag, "_rdata"}, 64'(rd), 64'(e[31:0]));
    if (wr && addr[1:0] == 2'b00 && addr < 32'(4*NR))
      check({tag, "_post"}, 64'(post), 64'(model[d][int'(addr[5:2])]));
  endtask

  task automatic check_regs(input int d, input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s_reg%0d", tag, i), 64'(regword(d, i)), 64'(model[d][i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, pre, post;
    logic        err;
    int          acc;

    PRESET = 1'b1; m_psel = 1'b0; m_pen = 1'b0; m_wr = 1'b0;
    m_addr = '0; m_wdata = '0; m_strb = 4'hF; m_dut = 0; status_in = 32'h0;
    clear_model();
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_pready0", 64'(bus0.PREADY), 64'(0));
    check("rst_pslverr0", 64'(bus0.PSLVERR), 64'(0));
    check("rst_prdata0", 64'(bus0.PRDATA), 64'(0));
    check("rst_pready3", 64'(bus3.PREADY), 64'(0));
    check("rst_state3", 64'(st3), 64'(IDLE));
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    check_regs(0, "rst_regs0");
    check_regs(1, "rst_regs3");

    run(0, 1'b0, 32'h00, 32'h0, 4'hF, "rd0_after_rst");
    run(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, "wr04_ws0");
    run(0, 1'b0, 32'h04, 32'h0, 4'hF, "rd04_ws0");

    expect_xfer(1, 1'b1, 32'h08, 32'hA5A51234, 4'hF);
    xfer(1, 1'b1, 32'h08, 32'hA5A51234, 4'hF, rd, err, acc, pre, post);
    void'(exp_q.pop_front());
    check("wr08_ws3_acc", 64'(acc), 64'(4));
    check("wr08_ws3_pre", 64'(pre), 64'(0));
    check("wr08_ws3_post", 64'(post), 64'(32'hA5A51234));
    check("wr08_ws3_err", 64'(err), 64'(0));
    run(1, 1'b0, 32'h08, 32'h0, 4'hF, "rd08_ws3");

    run(0, 1'b1, 32'h40, 32'h11111111, 4'hF, "wr40_oor");
    run(0, 1'b1, 32'h3C, 32'h22222222, 4'hF, "wr3c_ro");
    run(0, 1'b1, 32'h06, 32'h33333333, 4'hF, "wr06_mis");
    run(1, 1'b1, 32'h3C, 32'h44444444, 4'hF, "wr3c_ro_ws3");
    check_regs(0, "err_regs0");
    status_in = 32'h12345678;
    run(0, 1'b0, 32'h3C, 32'h0, 4'hF, "rd3c_status");
    run(1, 1'b0, 32'h3C, 32'h0, 4'hF, "rd3c_status_ws3");
    run(0, 1'b0, 32'h44, 32'h0, 4'hF, "rd44_oor");

    run(0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF, "wr0c_ones");
    run(0, 1'b1, 32'h0C, 32'h00000000, 4'b0101, "wr0c_strb");
    run(0, 1'b1, 32'h0C, 32'h0BADF00D, 4'b0000, "wr0c_strb0");
    run(0, 1'b0, 32'h0C, 32'h0, 4'b0011, "rd0c_strb");

    for (int n = 0; n < 24; n++) begin
      int          d;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 17)) * 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'd2;
      status_in = $urandom;
      run(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $sformatf("rand%0d", n));
    end
    check_regs(0, "rand_regs0");
    check_regs(1, "rand_regs3");

    // Abort: drop PSELx during the wait phase of a write.
    m_dut = 1; m_psel = 1'b1; m_pen = 1'b0; m_wr = 1'b1; m_addr = 32'h10;
    m_wdata = 32'hCAFEF00D; m_strb = 4'hF;
    @(posedge PCLK); #1;
    m_pen = 1'b1;
    @(posedge PCLK); #1;
    check("abort_wait_state", 64'(st3), 64'(WAIT));
    m_psel = 1'b0; m_pen = 1'b0;
    @(posedge PCLK); #1;
    check("abort_idle", 64'(st3), 64'(IDLE));
    check("abort_pready", 64'(bus3.PREADY), 64'(0));
    repeat (4) @(posedge PCLK);
    #1;
    check("abort_nowrite", 64'(regword(1, 4)), 64'(model[1][4]));

    run(1, 1'b1, 32'h08, 32'h5A5A5A5A, 4'hF, "pre_rst_wr08");
    // Reset arriving in the wait phase of a write.
    m_dut = 1; m_psel = 1'b1; m_pen = 1'b0; m_wr = 1'b1; m_addr = 32'h08;
    m_wdata = 32'h77777777; m_strb = 4'hF;
    @(posedge PCLK); #1;
    m_pen = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    #1;
    check("midrst_pready", 64'(bus3.PREADY), 64'(0));
    check("midrst_state", 64'(st3), 64'(IDLE));
    check("midrst_reg08", 64'(regword(1, 2)), 64'(0));
    m_psel = 1'b0; m_pen = 1'b0;
    clear_model();
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    run(1, 1'b0, 32'h08, 32'h0, 4'hF, "rd08_after_rst");
    run(0, 1'b0, 32'h04, 32'h0, 4'hF, "rd04_after_rst");
    check_regs(1, "final_regs3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer (slave) holding a bank of 32-bit memory-mapped registers, forming the responder end of the team's APB master. Decodes PADDR, services reads and writes with a configurable number of wait states, and flags illegal accesses on PSLVERR. Sits behind the APB master (one PSELx per instance) and exports its register contents to the surrounding logic.

## Interface

- NUM_REGS, 16: number of 32-bit registers; power of two, 2..256.
- WAIT_STATES, 0: extra access-phase cycles before PREADY; 0..15.
- RO_INDEX, NUM_REGS-1: index of the read-only status register.

- PCLK  in  1  sole clock; all logic on its rising edge.
- PRESET  in  1  reset: one clock, asynchronous, active-high.
- PSELx  in  1  slave select.
- PENABLE  in  1  access-phase marker.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address; word-aligned.
- PWDATA  in  32  write data.
- PSTRB  in  4  byte lanes; present only with APB_SLAVE_PSTRB_EN.
- STATUS_IN  in  32  value returned for reads of RO_INDEX.
- PRDATA  out  32  read data; valid when PREADY=1 and PWRITE=0.
- PREADY  out  1  transfer-complete strobe.
- PSLVERR  out  1  error response; valid only when PREADY=1.
- REGS_OUT  out  32*NUM_REGS  flattened register contents, reg i at [32*i+:32].

## Operation

- FSM states: IDLE, WAIT, DONE.
- IDLE: on PSELx=1, PENABLE=0 (setup phase), latch address, decode, and compute error; go to DONE if WAIT_STATES=0, else to WAIT with counter = WAIT_STATES.
- WAIT: counter decrements each cycle; go to DONE when the counter reaches 1.
- DONE: PREADY=1 for exactly one cycle; return to IDLE.
- Decode: index = PADDR[2 +: log2(NUM_REGS)].
- Error conditions:
  - PADDR[1:0] != 0.
  - PADDR >= 4*NUM_REGS.
  - Write to RO_INDEX.
- Write commit: at the rising edge where PSELx & PENABLE & PREADY & PWRITE & !PSLVERR. No other edge modifies a register.
- Read: PRDATA is loaded from the register (STATUS_IN for RO_INDEX) on entry to DONE; it is 0 on error and 0 whenever PREADY=0.
- Abort: if PSELx drops in WAIT or DONE, return to IDLE, PREADY=0, no write.
- Back-to-back transfers: the cycle after DONE may be a new setup phase; it is accepted from IDLE with no dead cycle.
- Reset, including mid-transfer: all registers 0, FSM to IDLE, no pending write survives.

## Timing

- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, REGS_OUT=0.
- PREADY, PRDATA and PSLVERR are registered; no combinational path from APB inputs.
- Access phase lasts WAIT_STATES+1 cycles; PREADY is high only in the last cycle.
- Total transfer is setup + WAIT_STATES + 1 cycles.
- REGS_OUT reflects a write on the cycle after the commit edge.
- PSLVERR is asserted only together with PREADY.

## Configuration

- APB_SLAVE_PSTRB_EN defined:
  - PSTRB port exists.
  - Write updates only byte lanes with PSTRB[n]=1.
  - PSTRB=0 on a write is a legal no-op (no error).
  - PSTRB on reads is ignored.
- APB_SLAVE_PSTRB_EN undefined: no PSTRB port; writes update all 4 bytes.

## Structure

- Shared package apb_pkg:
  - FSM state typedef (IDLE/WAIT/DONE).
  - APB data width 32 and strobe width 4.
  - Address-alignment constant 2.
- Sub-module apb_slave_decode (combinational): PADDR → index, out-of-range, misaligned, read-only-hit.
- Top holds the FSM, wait counter and register array.

## Test plan

- Reset then read addr 0x00 → PRDATA=0x0, PSLVERR=0, REGS_OUT all zero.
- WAIT_STATES=0: write 0xDEADBEEF to 0x04, read 0x04 → PREADY on the first access cycle, PRDATA=0xDEADBEEF.
- WAIT_STATES=3: write to 0x08 → PREADY low 3 access cycles, high on the 4th; register unchanged until the PREADY edge.
- Write to 0x40 (NUM_REGS=16) and to 0x3C (RO) → PSLVERR=1 with PREADY; no register changes. Read 0x3C with STATUS_IN=0x12345678 → 0x12345678, PSLVERR=0.
- Write to 0x06 → PSLVERR=1. With PSTRB_EN: reg 0x0C=0xFFFFFFFF, write 0x00000000 with PSTRB=4'b0101 → 0xFF00FF00.
- PRESET asserted during WAIT of a write → PREADY=0 immediately, target register reads 0 after reset; PSELx dropped in WAIT → IDLE, no write.
